// File: rtl/mult_div_unit_if.sv
// Bus between the E stage and the multiply/divide unit: launch, moves,
// exception suppression, and the HI/LO/busy results coming back.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, mthi, mtlo, wdata, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, mthi, mtlo, wdata, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Operands are latched at launch; the result is written on the edge that
// drops busy (5 cycles for multiply, 10 for divide).
module mult_div_unit (
  input  logic            clk,
  input  logic            resetn,
  mult_div_unit_if.slave  bus
);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [1:0]  op_q, op_d;

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic               negA, negB;
  logic        [31:0] absA, absB, divisor, uQuo, uRem, quo, rem;
  logic        [31:0] resHi, resLo;
  logic               divZero;

  // Result datapath computed from the latched operands only, so changes
  // on the bus during RUN cannot disturb the in-flight operation.
  always_comb begin
    sProd   = $signed({{32{opA_q[31]}}, opA_q}) * $signed({{32{opB_q[31]}}, opB_q});
    uProd   = {32'd0, opA_q} * {32'd0, opB_q};
    negA    = (op_q == OP_DIV) && opA_q[31];
    negB    = (op_q == OP_DIV) && opB_q[31];
    absA    = negA ? (32'd0 - opA_q) : opA_q;
    absB    = negB ? (32'd0 - opB_q) : opB_q;
    divisor = (absB == 32'd0) ? 32'd1 : absB;
    uQuo    = absA / divisor;
    uRem    = absA % divisor;
    quo     = (negA ^ negB) ? (32'd0 - uQuo) : uQuo;
    rem     = negA ? (32'd0 - uRem) : uRem;
    divZero = op_q[1] && (opB_q == 32'd0);
    resHi   = 32'd0;
    resLo   = 32'd0;
    case (op_q)
      OP_MULT:  begin resHi = sProd[63:32]; resLo = sProd[31:0]; end
      OP_MULTU: begin resHi = uProd[63:32]; resLo = uProd[31:0]; end
      default:  begin resHi = rem;          resLo = quo;         end
    endcase
  end

  // Next-state logic: launch, HI/LO moves in IDLE, countdown and write-back in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.req) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = bus.md_op[1] ? 4'd10 : 4'd5;
          opA_d   = bus.rs_val;
          opB_d   = bus.rt_val;
          op_d    = bus.md_op;
        end else if (!bus.req) begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!divZero) begin
            hi_d = resHi;
            lo_d = resLo;
          end
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opA_q   <= 32'd0;
      opB_q   <= 32'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written
// sequences for disturbance, mid-RUN reset and req suppression.
module tb_mult_div_unit;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] preHi;
    logic [31:0] preLo;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expCycles;
  } vec_t;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  int   n;
  vec_t vecs[10];

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.start  = 1'b0;
    bus.md_op  = 2'b00;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wdata  = 32'd0;
    bus.req    = 1'b0;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    bus.mthi = 1'b1; bus.wdata = h;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = l;
    @(posedge clk); #1;
    clearInputs();
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic withMtlo, input logic [31:0] wd);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.mtlo   = withMtlo;
    bus.wdata  = wd;
    @(posedge clk); #1;
    clearInputs();
  endtask

  // kind 0: nothing; 1: re-start plus MTHI 0xAA; 2: pull resetn low.
  task automatic runBusy(input int injectAt, input int kind, output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 30) begin
      cycles++;
      if (cycles == injectAt && kind == 1) begin
        bus.start = 1'b1; bus.md_op = 2'b00; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
        bus.mthi = 1'b1; bus.wdata = 32'hAA;
      end else if (cycles == injectAt && kind == 2) begin
        resetn = 1'b0;
      end else begin
        clearInputs();
      end
      @(posedge clk); #1;
    end
    clearInputs();
    resetn = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{2'b11, 32'h00000007, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{2'b11, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 10};
    vecs[6] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFD, 10};
    vecs[7] = '{2'b00, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[8] = '{2'b01, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 5};
    vecs[9] = '{2'b10, 32'd5, 32'd0, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10};

    clearInputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset hi", bus.hi, 32'd0);
    checkOutput("reset lo", bus.lo, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].preHi, vecs[i].preLo);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'd0);
      runBusy(0, 0, n);
      checkOutput($sformatf("vec%0d cycles", i), 32'(n), 32'(vecs[i].expCycles));
      checkOutput($sformatf("vec%0d hi", i), bus.hi, vecs[i].expHi);
      checkOutput($sformatf("vec%0d lo", i), bus.lo, vecs[i].expLo);
    end

    // Restart and MTHI during RUN must be ignored.
    preload(32'h1, 32'h2);
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 32'd0);
    runBusy(3, 1, n);
    checkOutput("disturb cycles", 32'(n), 32'd10);
    checkOutput("disturb hi", bus.hi, 32'd2);
    checkOutput("disturb lo", bus.lo, 32'd14);
    @(posedge clk); #1;
    checkOutput("disturb idle", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a DIV.
    preload(32'h55, 32'h66);
    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0, 32'd0);
    runBusy(4, 2, n);
    checkOutput("midreset cycles", 32'(n), 32'd4);
    checkOutput("midreset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midreset hi", bus.hi, 32'd0);
    checkOutput("midreset lo", bus.lo, 32'd0);
    bus.mtlo = 1'b1; bus.wdata = 32'h1234;
    @(posedge clk); #1;
    clearInputs();
    checkOutput("mtlo lo", bus.lo, 32'h1234);
    checkOutput("mtlo hi", bus.hi, 32'd0);

    // req suppresses start and moves.
    preload(32'h77, 32'h88);
    bus.start = 1'b1; bus.req = 1'b1; bus.md_op = 2'b00; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    bus.mthi = 1'b1; bus.wdata = 32'h99;
    @(posedge clk); #1;
    clearInputs();
    checkOutput("req busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("req hi", bus.hi, 32'h77);
    checkOutput("req lo", bus.lo, 32'h88);
    @(posedge clk); #1;
    checkOutput("req busy later", {31'd0, bus.busy}, 32'd0);

    // start wins over a simultaneous MTLO.
    applyStimulus(2'b01, 32'd3, 32'd5, 1'b1, 32'h5555);
    runBusy(0, 0, n);
    checkOutput("prio cycles", 32'(n), 32'd5);
    checkOutput("prio hi", bus.hi, 32'd0);
    checkOutput("prio lo", bus.lo, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
